// File: rtl/float_to_log_arb_pkg.sv
// Shared types and sizing helpers for the shared float-to-log converter arbiter.
package float_to_log_arb_pkg;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned credit_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic sign;
    logic is_inf;
    logic is_zero;
  } log_flags_t;

endpackage

// File: rtl/FloatSignedToLog.sv
// Signed linear float to fixed-point log2 converter (Mitchell approximation of
// the fraction); log result is a signed M.F value with saturate/inf on overflow.
module FloatSignedToLog #(
  parameter int unsigned EXP_IN       = 10,
  parameter int unsigned FRAC_IN      = 10,
  parameter int unsigned M            = 3,
  parameter int unsigned F            = 4,
  parameter int unsigned SATURATE_MAX = 1
) (
  input  logic               sign,
  input  logic               isInf,
  input  logic               isZero,
  input  logic [EXP_IN-1:0]  linExp,
  input  logic [FRAC_IN-1:0] linFrac,
  output logic               outSign,
  output logic               outIsInf,
  output logic               outIsZero,
  output logic [M-1:0]       outLogExp,
  output logic [F-1:0]       outLogFrac
);

  localparam int unsigned W   = EXP_IN + FRAC_IN + F + 1;
  localparam int unsigned SHR = (FRAC_IN >= F) ? FRAC_IN - F : 0;
  localparam int unsigned SHL = (FRAC_IN >= F) ? 0 : F - FRAC_IN;
  localparam logic signed [W-1:0] MAXV = W'((64'sd1 <<< (M + F - 1)) - 64'sd1);
  localparam logic signed [W-1:0] MINV = ~MAXV;

  logic signed [W-1:0] full;
  logic signed [W-1:0] fx;

  always_comb begin
    // exp.frac as a fixed-point log2, rescaled to F fraction bits (floor)
    full = (W'($signed(linExp)) <<< FRAC_IN) + $signed(W'(linFrac));
    fx   = (FRAC_IN >= F) ? (full >>> SHR) : (full <<< SHL);

    outSign    = sign;
    outIsInf   = 1'b0;
    outIsZero  = 1'b0;
    outLogExp  = '0;
    outLogFrac = '0;
    if (isInf) begin
      outIsInf = 1'b1;
    end else if (isZero) begin
      outIsZero = 1'b1;
    end else if (fx > MAXV) begin
      if (SATURATE_MAX != 0) {outLogExp, outLogFrac} = MAXV[M+F-1:0];
      else                   outIsInf = 1'b1;
    end else if (fx < MINV) begin
      outIsZero = 1'b1;
    end else begin
      {outLogExp, outLogFrac} = fx[M+F-1:0];
    end
  end

endmodule

// File: rtl/float_to_log_arbiter_round_robin_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from the pointer; the
// pointer moves past the winner only when a grant is actually issued.
module round_robin_arbiter
  import float_to_log_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant
);

  localparam int unsigned PW = id_width(NUM_REQ);

  logic [PW-1:0] pointer;
  logic [PW-1:0] idx;
  logic [PW-1:0] gidx;
  logic          found;

  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = PW'((32'(pointer) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        gidx       = idx;
        grant[idx] = enable;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pointer <= '0;
    end else if (enable && found) begin
      pointer <= (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + PW'(1);
    end
  end

endmodule

// File: rtl/float_to_log_arbiter.sv
// One FloatSignedToLog shared by NUM_REQ requesters: round-robin issue, LATENCY
// pipeline, credit-protected result FIFO. Optional stats: FLOAT_TO_LOG_ARB_STATS_EN.
module float_to_log_arbiter
  import float_to_log_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned EXP_IN       = 10,
  parameter int unsigned FRAC_IN      = 10,
  parameter int unsigned M            = 3,
  parameter int unsigned F            = 4,
  parameter int unsigned SATURATE_MAX = 1,
  parameter int unsigned LATENCY      = 2,
  parameter int unsigned FIFO_DEPTH   = LATENCY + 2,
  localparam int unsigned IDW         = id_width(NUM_REQ)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         reqValid,
  output logic [NUM_REQ-1:0]         reqReady,
  input  logic [NUM_REQ-1:0]         reqSign,
  input  logic [NUM_REQ-1:0]         reqIsInf,
  input  logic [NUM_REQ-1:0]         reqIsZero,
  input  logic [NUM_REQ*EXP_IN-1:0]  reqExp,
  input  logic [NUM_REQ*FRAC_IN-1:0] reqFrac,
  output logic                       outValid,
  input  logic                       outReady,
  output logic [IDW-1:0]             outId,
  output logic                       outSign,
  output logic                       outIsInf,
  output logic                       outIsZero,
  output logic [M-1:0]               outLogExp,
  output logic [F-1:0]               outLogFrac
`ifdef FLOAT_TO_LOG_ARB_STATS_EN
  ,
  output logic [31:0]                statIssued,
  output logic [31:0]                statStallCycles
`endif
);

  localparam int unsigned CW  = credit_width(FIFO_DEPTH);
  localparam int unsigned FAW = id_width(FIFO_DEPTH);

  typedef struct packed {
    logic [IDW-1:0] id;
    logic           sign;
    logic           is_inf;
    logic           is_zero;
    logic [M-1:0]   log_exp;
    logic [F-1:0]   log_frac;
  } entry_t;

  logic [CW-1:0]      credits;
  logic               enable;
  logic               issue;
  logic               push;
  logic               pop;

  logic [IDW-1:0]     gid;
  logic               sel_sign, sel_inf, sel_zero;
  logic [EXP_IN-1:0]  sel_exp;
  logic [FRAC_IN-1:0] sel_frac;
  logic               c_sign, c_inf, c_zero;
  logic [M-1:0]       c_exp;
  logic [F-1:0]       c_frac;
  entry_t             conv_e;

  entry_t             stage_d [LATENCY];
  logic [LATENCY-1:0] stage_v;

  entry_t             mem [FIFO_DEPTH];
  entry_t             head;
  logic [FAW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]      count;

  // Holding ready low during reset keeps the reset edge free of transfers.
  assign enable = (credits != '0) && !reset;
  assign issue  = |reqReady;
  assign push   = stage_v[LATENCY-1];
  assign pop    = outValid && outReady;

  round_robin_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clock  (clock),
    .reset  (reset),
    .req    (reqValid),
    .enable (enable),
    .grant  (reqReady)
  );

  always_comb begin
    gid      = '0;
    sel_sign = 1'b0;
    sel_inf  = 1'b0;
    sel_zero = 1'b0;
    sel_exp  = '0;
    sel_frac = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (reqReady[i]) begin
        gid      = IDW'(i);
        sel_sign = reqSign[i];
        sel_inf  = reqIsInf[i];
        sel_zero = reqIsZero[i];
        sel_exp  = reqExp[i*EXP_IN +: EXP_IN];
        sel_frac = reqFrac[i*FRAC_IN +: FRAC_IN];
      end
    end
  end

  FloatSignedToLog #(
    .EXP_IN       (EXP_IN),
    .FRAC_IN      (FRAC_IN),
    .M            (M),
    .F            (F),
    .SATURATE_MAX (SATURATE_MAX)
  ) u_conv (
    .sign       (sel_sign),
    .isInf      (sel_inf),
    .isZero     (sel_zero),
    .linExp     (sel_exp),
    .linFrac    (sel_frac),
    .outSign    (c_sign),
    .outIsInf   (c_inf),
    .outIsZero  (c_zero),
    .outLogExp  (c_exp),
    .outLogFrac (c_frac)
  );

  always_comb begin
    conv_e          = '0;
    conv_e.id       = gid;
    conv_e.sign     = c_sign;
    conv_e.is_inf   = c_inf;
    conv_e.is_zero  = c_zero;
    conv_e.log_exp  = c_exp;
    conv_e.log_frac = c_frac;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stage_v <= '0;
    end else begin
      stage_v[0] <= issue;
      for (int unsigned s = 1; s < LATENCY; s++) stage_v[s] <= stage_v[s-1];
    end
  end

  always_ff @(posedge clock) begin
    stage_d[0] <= conv_e;
    for (int unsigned s = 1; s < LATENCY; s++) stage_d[s] <= stage_d[s-1];
  end

  function automatic logic [FAW-1:0] fifo_next(input logic [FAW-1:0] p);
    return (p == FAW'(FIFO_DEPTH - 1)) ? '0 : p + FAW'(1);
  endfunction

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= stage_d[LATENCY-1];
  end

  // Credits count free FIFO slots minus results still in the pipeline.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      credits <= CW'(FIFO_DEPTH);
    end else begin
      if (push) wr_ptr <= fifo_next(wr_ptr);
      if (pop)  rd_ptr <= fifo_next(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
      if (issue && !pop)      credits <= credits - CW'(1);
      else if (!issue && pop) credits <= credits + CW'(1);
    end
  end

  assign outValid   = (count != '0);
  assign head       = mem[rd_ptr];
  assign outId      = outValid ? head.id       : '0;
  assign outSign    = outValid ? head.sign     : 1'b0;
  assign outIsInf   = outValid ? head.is_inf   : 1'b0;
  assign outIsZero  = outValid ? head.is_zero  : 1'b0;
  assign outLogExp  = outValid ? head.log_exp  : '0;
  assign outLogFrac = outValid ? head.log_frac : '0;

`ifdef FLOAT_TO_LOG_ARB_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      statIssued      <= '0;
      statStallCycles <= '0;
    end else begin
      if (issue) statIssued <= statIssued + 32'd1;
      if ((|reqValid) && (credits == '0)) statStallCycles <= statStallCycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_float_to_log_arbiter.sv
// Scoreboard bench for float_to_log_arbiter: arbitration/credit model checks
// reqReady every cycle, a monitor checks every popped result against a log2 model.
module tb_float_to_log_arbiter;

  localparam int NR = 4, EI = 10, FI = 10, MM = 3, FF = 4, LAT = 2, DEPTH = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic [NR-1:0]   reqValid, reqReady, reqSign, reqIsInf, reqIsZero;
  logic [NR*EI-1:0] reqExp;
  logic [NR*FI-1:0] reqFrac;
  logic            outValid, outReady;
  logic [1:0]      outId;
  logic            outSign, outIsInf, outIsZero;
  logic [MM-1:0]   outLogExp;
  logic [FF-1:0]   outLogFrac;
`ifdef FLOAT_TO_LOG_ARB_STATS_EN
  logic [31:0]     statIssued, statStallCycles;
`endif

  always #5 clock = ~clock;

  float_to_log_arbiter #(
    .NUM_REQ(NR), .EXP_IN(EI), .FRAC_IN(FI), .M(MM), .F(FF),
    .SATURATE_MAX(1), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset),
    .reqValid(reqValid), .reqReady(reqReady), .reqSign(reqSign),
    .reqIsInf(reqIsInf), .reqIsZero(reqIsZero), .reqExp(reqExp), .reqFrac(reqFrac),
    .outValid(outValid), .outReady(outReady), .outId(outId), .outSign(outSign),
    .outIsInf(outIsInf), .outIsZero(outIsZero), .outLogExp(outLogExp), .outLogFrac(outLogFrac)
`ifdef FLOAT_TO_LOG_ARB_STATS_EN
    , .statIssued(statIssued), .statStallCycles(statStallCycles)
`endif
  );

  typedef struct {
    int id;
    bit sign, inf, zero;
    int lexp, lfrac;
  } exp_t;

  exp_t sbq[$];
  int checks = 0, failures = 0;
  int outstanding = 0, mptr = 0;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, expv, $time);
    end
  endtask

  // value = (1+f) * 2^e, log2 approximated as e + f, floored to FF fraction bits
  function automatic exp_t model(input int id, input bit s, input bit inf, input bit z,
                                 input int e, input int f);
    exp_t r;
    int v, lim;
    r.id = id; r.sign = s; r.inf = 0; r.zero = 0; r.lexp = 0; r.lfrac = 0;
    lim = 1 << (MM + FF - 1);
    v = e * (1 << FF) + f / (1 << (FI - FF));
    if (inf) r.inf = 1;
    else if (z) r.zero = 1;
    else if (v > lim - 1) begin
      r.lexp = (1 << (MM - 1)) - 1;
      r.lfrac = (1 << FF) - 1;
    end else if (v < -lim) r.zero = 1;
    else begin
      r.lfrac = ((v % (1 << FF)) + (1 << FF)) % (1 << FF);
      r.lexp = (v - r.lfrac) / (1 << FF);
    end
    return r;
  endfunction

  // Arbitration/credit tracker: expected reqReady, scoreboard push on issue.
  always @(negedge clock) begin
    logic [NR-1:0] er;
    int g, idx;
    bit p;
    if (reset) begin
      check("ready_in_reset", int'(reqReady), 0);
      sbq.delete();
      outstanding = 0;
      mptr = 0;
    end else begin
      er = '0;
      g = -1;
      if (outstanding < DEPTH)
        for (int k = 0; k < NR; k++) begin
          idx = (mptr + k) % NR;
          if (g < 0 && reqValid[idx]) g = idx;
        end
      if (g >= 0) er[g] = 1'b1;
      check("req_ready", int'(reqReady), int'(er));
      p = outValid && outReady;
      if (g >= 0) begin
        sbq.push_back(model(g, reqSign[g], reqIsInf[g], reqIsZero[g],
                            int'($signed(reqExp[g*EI +: EI])), int'(reqFrac[g*FI +: FI])));
        mptr = (g + 1) % NR;
        outstanding++;
      end
      if (p) outstanding--;
    end
  end

  // Result monitor.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && outValid && outReady) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out actual=outId %0d expected=no result t=%0t", outId, $time);
      end else begin
        e = sbq.pop_front();
        check("out_id", int'(outId), e.id);
        check("out_sign", int'(outSign), int'(e.sign));
        check("out_inf", int'(outIsInf), int'(e.inf));
        check("out_zero", int'(outIsZero), int'(e.zero));
        check("out_log_exp", int'($signed(outLogExp)), e.lexp);
        check("out_log_frac", int'(outLogFrac), e.lfrac);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

  task automatic set_req(input int i, input bit s, input bit inf, input bit z,
                         input int e, input int f);
    reqSign[i] = s;
    reqIsInf[i] = inf;
    reqIsZero[i] = z;
    reqExp[i*EI +: EI] = EI'(e);
    reqFrac[i*FI +: FI] = FI'(f);
    reqValid[i] = 1'b1;
  endtask

  task automatic random_req(input int i);
    int e;
    if ($urandom % 8 == 0) e = int'($urandom % 1024) - 512;
    else e = int'($urandom_range(16, 0)) - 8;
    set_req(i, bit'($urandom % 2), ($urandom % 16) == 0, ($urandom % 16) == 0,
            e, int'($urandom % 1024));
  endtask

  task automatic step(output logic [NR-1:0] acc);
    @(negedge clock);
    acc = reqValid & reqReady;
    @(posedge clock);
    #1;
    reqValid = reqValid & ~acc;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic run_one(input int i, input bit s, input bit inf, input bit z,
                         input int e, input int f, output int lat,
                         output int oid, output int osg, output int oinf,
                         output int ozr, output int oexp, output int ofr);
    logic [NR-1:0] acc;
    bit found;
    acc = '0;
    lat = 0; oid = -1; osg = -1; oinf = -1; ozr = -1; oexp = -99; ofr = -1;
    set_req(i, s, inf, z, e, f);
    for (int n = 0; n < 10; n++) begin
      step(acc);
      if (acc != '0) break;
    end
    check("single_accept", int'(acc), 1 << i);
    found = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      lat++;
      if (outValid) begin
        found = 1;
        oid = int'(outId); osg = int'(outSign); oinf = int'(outIsInf);
        ozr = int'(outIsZero); oexp = int'($signed(outLogExp)); ofr = int'(outLogFrac);
        break;
      end
    end
    check("single_out_seen", int'(found), 1);
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [NR-1:0] acc;
    int lat, oid, osg, oinf, ozr, oexp, ofr, n_iss;
    bit quiet;

    reset = 1'b1; outReady = 1'b1;
    reqValid = '0; reqSign = '0; reqIsInf = '0; reqIsZero = '0; reqExp = '0; reqFrac = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_out_valid", int'(outValid), 0);
    check("reset_out_id", int'(outId), 0);
    check("reset_out_exp", int'(outLogExp), 0);
    check("reset_out_frac", int'(outLogFrac), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // single request, latency
    run_one(2, 0, 0, 0, 2, 0, lat, oid, osg, oinf, ozr, oexp, ofr);
    check("latency", lat, LAT + 1);
    check("t1_id", oid, 2);
    check("t1_exp", oexp, 2);
    check("t1_frac", ofr, 0);
    repeat (3) step(acc);

    // continuous round robin
    do_reset();
    n_iss = 0;
    for (int c = 0; c < 16; c++) begin
      for (int i = 0; i < NR; i++) if (!reqValid[i]) random_req(i);
      step(acc);
      if (acc != '0) n_iss++;
    end
    check("rr_issue_per_cycle", n_iss, 16);
    reqValid = '0;
    repeat (6) step(acc);

    // backpressure
    do_reset();
    outReady = 1'b0;
    n_iss = 0;
    for (int c = 0; c < 14; c++) begin
      for (int i = 0; i < NR; i++) if (!reqValid[i]) random_req(i);
      step(acc);
      if (acc != '0) n_iss++;
    end
    check("bp_issues", n_iss, DEPTH);
`ifdef FLOAT_TO_LOG_ARB_STATS_EN
    check("stat_issued", int'(statIssued), 4);
    check("stat_stalls", int'(statStallCycles), 10);
`endif
    outReady = 1'b1;
    n_iss = 0;
    step(acc);
    if (acc != '0) n_iss++;
    outReady = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step(acc);
      if (acc != '0) n_iss++;
    end
    check("bp_one_more", n_iss, 1);
    reqValid = '0;

    // conversion corners
    do_reset();
    outReady = 1'b1;
    run_one(1, 1, 0, 0, 5, 0, lat, oid, osg, oinf, ozr, oexp, ofr);
    check("sat_exp", oexp, 3);
    check("sat_frac", ofr, 15);
    check("sat_sign", osg, 1);
    check("sat_not_inf", oinf, 0);
    run_one(1, 0, 0, 1, 1, 7, lat, oid, osg, oinf, ozr, oexp, ofr);
    check("zero_flag", ozr, 1);
    run_one(3, 1, 1, 0, 0, 0, lat, oid, osg, oinf, ozr, oexp, ofr);
    check("inf_flag", oinf, 1);
    check("inf_id", oid, 3);
    repeat (3) step(acc);

    // reset with results in flight and queued
    outReady = 1'b0;
    n_iss = 0;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < NR; i++) if (!reqValid[i]) random_req(i);
      step(acc);
      if (acc != '0) n_iss++;
    end
    check("flush_prep_issues", n_iss, 3);
    reqValid = '0;
    do_reset();
    @(negedge clock);
    check("flush_out_valid", int'(outValid), 0);
    @(posedge clock);
    #1;
    n_iss = 0;
    for (int i = 0; i < NR; i++) random_req(i);
    step(acc);
    check("flush_first_grant", int'(acc), 1);
    if (acc != '0) n_iss++;
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < NR; i++) if (!reqValid[i]) random_req(i);
      step(acc);
      if (acc != '0) n_iss++;
    end
    check("flush_credits", n_iss, DEPTH);
    reqValid = '0;

    // random stress
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) if (!reqValid[i] && ($urandom % 2 == 0)) random_req(i);
      outReady = ($urandom % 4) != 0;
      step(acc);
    end
    reqValid = '0;
    outReady = 1'b1;
    quiet = 0;
    for (int c = 0; c < 50; c++) begin
      step(acc);
      if (sbq.size() == 0 && !outValid) begin
        quiet = 1;
        break;
      end
    end
    check("drain_done", int'(quiet), 1);
    check("scoreboard_empty", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
